// File: rtl/mem_if_pkg.sv
// Shared memory-interface types for the core's load/store port.
// Used by the MEM stage (initiator) and by dmem_responder (responder).
//   mem_req_t    : one captured request {write, addr, wdata, wstrb}
//   mem_rsp_t    : one response payload {rdata, err}
//   dmem_state_e : responder FSM state, visible to anything that imports this package
//   addr_err()   : misaligned / out-of-range check for a byte address
package mem_if_pkg;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // A request is in error when it is not word aligned or its word index
    // falls outside the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte-lane write enables.
// Synchronous write, asynchronous read, no reset (contents survive rst_n).
// Ports:
//   clk    in   clock, writes happen on the rising edge
//   we     in   4  byte-lane write enables, bit i -> bits [8i+7:8i]
//   idx    in   AW word index shared by read and write
//   wdata  in   32 write data
//   rdata  out  32 read data for idx (combinational)
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port. Accepts one word
// request at a time, waits LATENCY cycles in BUSY, performs the access on the
// edge that enters RESP and holds the response until it is taken.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid && ready are both high; the sender keeps valid and payload stable
// until that edge. req_ready and rsp_valid are registered, never derived
// combinationally from the other side's signals.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_wdata, req_wstrb  store data and byte-lane enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data, 0 for stores and errors
//   rsp_err               misaligned or out-of-range request
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    mem_req_t         req_q;
    mem_rsp_t         rsp_q;
    logic             rsp_valid_q;
    logic             req_ready_q;

    mem_req_t         in_req;
    mem_req_t         acc_req;
    logic             acc_err;
    logic             fire;
    logic [3:0]       mem_we;
    logic [31:0]      mem_rdata;
    mem_rsp_t         rsp_d;

    assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

    // With LATENCY == 0 the access happens on the acceptance edge, so the
    // array must see the live request rather than the captured copy.
    assign acc_req = (state_q == IDLE) ? in_req : req_q;
    assign acc_err = addr_err(acc_req.addr, DEPTH_WORDS);

    assign fire = ((state_q == IDLE) && req_valid && req_ready_q && (LATENCY == 0)) ||
                  ((state_q == BUSY) && (cnt_q == CNT_W'(1)));

    // Stores commit only on the edge that enters RESP; a reset before that
    // edge returns state_q to IDLE and the write never happens.
    assign mem_we = (fire && acc_req.write && !acc_err) ? acc_req.wstrb : 4'b0000;

    assign rsp_d.rdata = (!acc_req.write && !acc_err) ? mem_rdata : 32'h0;
    assign rsp_d.err   = acc_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (acc_req.addr[AW+1:2]),
        .wdata (acc_req.wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // req_ready comes up one cycle after reset release.
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_q       <= in_req;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_q       <= rsp_d;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_W'(LATENCY);
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_q       <= rsp_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule
